// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for a combinational ALU with an 8x16 register file; optional flags via ALU_ISSUE_FLAGS_EN.
// Latency: accept -> operands next cycle -> result captured 2 cycles after accept -> write-back 3 cycles after accept.
// Backpressure: instr_ready is high only in IDLE; instr_valid is ignored while an instruction is in flight.
module alu_issue_ctrl #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [2:0]       op_select,
    input  logic [WIDTH-1:0] result,
    output logic             done,
    output logic [2:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             err,
    output logic             flag_z,
    output logic             flag_n,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_EX   = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] OP_PASS_B = 3'd4;
    localparam logic [2:0] OP_LDI    = 3'd5;

    logic [1:0]       state;
    logic [2:0]       rd_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] regs [NREGS];

    logic [2:0]       dec_op;
    logic [2:0]       dec_rd;
    logic [2:0]       dec_ra;
    logic [2:0]       dec_rb;
    logic [6:0]       dec_imm;
    logic             dec_legal;
    logic             dec_ldi;
    logic             accept;

    assign dec_op    = instr[15:13];
    assign dec_rd    = instr[12:10];
    assign dec_ra    = instr[9:7];
    assign dec_rb    = instr[6:4];
    assign dec_imm   = instr[6:0];
    assign dec_legal = (dec_op <= OP_LDI);
    assign dec_ldi   = (dec_op == OP_LDI);

    assign instr_ready = (state == S_IDLE);
    assign accept      = instr_ready && instr_valid;
    assign dbg_data    = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_q      <= 3'd0;
            op_a      <= '0;
            op_b      <= '0;
            op_select <= 3'd0;
            result_q  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            wb_addr   <= 3'd0;
            wb_data   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (dec_legal) begin
                            // Operands are snapshotted here, so rd==ra/rb sees the old value.
                            rd_q  <= dec_rd;
                            state <= S_RD;
                            if (dec_ldi) begin
                                op_a      <= '0;
                                op_b      <= {{(WIDTH-7){1'b0}}, dec_imm};
                                op_select <= OP_PASS_B;
                            end else begin
                                op_a      <= regs[dec_ra];
                                op_b      <= regs[dec_rb];
                                op_select <= dec_op;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    state <= S_EX;
                end
                S_EX: begin
                    // done/wb_* are registered so they are valid for the whole WB cycle.
                    result_q <= result;
                    done     <= 1'b1;
                    wb_addr  <= rd_q;
                    wb_data  <= result;
                    state    <= S_WB;
                end
                S_WB: begin
                    regs[rd_q] <= result_q;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    logic flag_z_q;
    logic flag_n_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (state == S_WB) begin
            flag_z_q <= (result_q == '0);
            flag_n_q <= result_q[WIDTH-1];
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl against a register-level reference model.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  op_select;
    logic [15:0] result;
    logic        done;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        err;
    logic        flag_z;
    logic        flag_n;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_vec;
    int n_err;

    logic [15:0] mregs [8];
    logic        m_z;
    logic        m_n;

    alu_issue_ctrl #(.NREGS(8), .WIDTH(16)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .op_a(op_a), .op_b(op_b), .op_select(op_select),
        .result(result), .done(done), .wb_addr(wb_addr), .wb_data(wb_data),
        .err(err), .flag_z(flag_z), .flag_n(flag_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational ALU on the other side of the port.
    always_comb begin
        result = 16'h0000;
        case (op_select)
            3'd0: result = op_a + op_b;
            3'd1: result = op_a - op_b;
            3'd2: result = ~(op_a & op_b);
            3'd3: result = op_a;
            3'd4: result = op_b;
            default: result = 16'h0000;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int ra, input int rb);
        logic [15:0] w;
        w = {op[2:0], rd[2:0], ra[2:0], rb[2:0], 4'b0000};
        return w;
    endfunction

    function automatic logic [15:0] ldi(input int rd, input int imm);
        logic [15:0] w;
        w = {3'd5, rd[2:0], 3'b000, imm[6:0]};
        return w;
    endfunction

    function automatic logic flags_built();
`ifdef ALU_ISSUE_FLAGS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = i[2:0];
            #1;
            chk(tag, dbg_data, mregs[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
        m_z = 1'b0;
        m_n = 1'b0;
    endtask

    // Issue one instruction from IDLE and follow it through to write-back.
    task automatic run_instr(input logic [15:0] ins);
        int op, rd, ra, rb;
        logic [15:0] a, b, v;
        logic [2:0] sel;
        op = int'(ins[15:13]);
        rd = int'(ins[12:10]);
        ra = int'(ins[9:7]);
        rb = int'(ins[6:4]);
        @(negedge clk);
        chk("ready_idle", instr_ready, 1);
        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
        if (op >= 6) begin
            @(negedge clk);
            chk("err_pulse", err, 1);
            chk("err_no_done", done, 0);
            chk("err_ready", instr_ready, 1);
            @(negedge clk);
            chk("err_clear", err, 0);
            chk("err_no_done2", done, 0);
            return;
        end
        if (op == 5) begin
            a = 16'h0000;
            b = {9'b0, ins[6:0]};
            sel = 3'd4;
            v = b;
        end else begin
            a = mregs[ra];
            b = mregs[rb];
            sel = ins[15:13];
            case (op)
                0: v = a + b;
                1: v = a - b;
                2: v = ~(a & b);
                3: v = a;
                default: v = b;
            endcase
        end
        @(negedge clk);
        chk("op_a", op_a, a);
        chk("op_b", op_b, b);
        chk("op_sel", op_select, sel);
        chk("ready_rd", instr_ready, 0);
        chk("done_rd", done, 0);
        @(negedge clk);
        chk("ready_ex", instr_ready, 0);
        chk("done_ex", done, 0);
        @(negedge clk);
        dbg_addr = rd[2:0];
        #1;
        chk("done_wb", done, 1);
        chk("wb_addr", wb_addr, rd);
        chk("wb_data", wb_data, v);
        chk("dbg_pre", dbg_data, mregs[rd]);
        mregs[rd] = v;
        if (flags_built()) begin
            m_z = (v == 16'h0000);
            m_n = v[15];
        end
        @(negedge clk);
        #1;
        chk("done_end", done, 0);
        chk("ready_back", instr_ready, 1);
        chk("dbg_post", dbg_data, v);
        chk("flag_z", flag_z, m_z);
        chk("flag_n", flag_n, m_n);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, instr_ready, 1);
        chk({tag, "_op_a"}, op_a, 0);
        chk({tag, "_op_b"}, op_b, 0);
        chk({tag, "_sel"}, op_select, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_wba"}, wb_addr, 0);
        chk({tag, "_wbd"}, wb_data, 0);
        chk({tag, "_fz"}, flag_z, 0);
        chk({tag, "_fn"}, flag_n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0000;
        dbg_addr = 3'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");
        check_all_regs("rst_regs");

        // Directed program from the plan.
        run_instr(ldi(1, 5));
        run_instr(ldi(2, 3));
        run_instr(enc(0, 3, 1, 2));
        run_instr(enc(1, 4, 2, 1));
        run_instr(enc(2, 5, 1, 1));
        run_instr(enc(3, 6, 3, 0));
        run_instr(enc(1, 7, 1, 1));
        chk("dir_r4", mregs[4], 16'hFFFE);
        chk("dir_r5", mregs[5], 16'hFFFA);

        run_instr(enc(6, 2, 1, 1));
        check_all_regs("ill6_regs");
        run_instr(enc(7, 0, 3, 4));
        check_all_regs("ill7_regs");

        // Back-to-back with instr_valid held: ADD R1,R1,R1 from R1=5.
        @(negedge clk);
        instr = enc(0, 1, 1, 1);
        instr_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            chk("b2b_ready", instr_ready, (k % 4 == 0) ? 1 : 0);
            chk("b2b_done", done, (k % 4 == 3) ? 1 : 0);
            if (k % 4 == 3) chk("b2b_wb", wb_data, (k == 3) ? 10 : 20);
            @(posedge clk);
        end
        #1;
        instr_valid = 1'b0;
        mregs[1] = 16'd20;
        if (flags_built()) begin
            m_z = 1'b0;
            m_n = 1'b0;
        end
        @(negedge clk);
        chk("b2b_ready_end", instr_ready, 1);
        chk("b2b_fz", flag_z, m_z);
        check_all_regs("b2b_regs");

        // Reset in the EX cycle of ADD R3,R1,R2.
        @(negedge clk);
        instr = enc(0, 3, 1, 2);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("midrst");
        check_all_regs("midrst_regs");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_nodone", done, 0);
        end
        run_instr(ldi(3, 7'h2A));
        run_instr(enc(0, 4, 3, 3));

        // Randomized stream: seed every register, then mixed ops including illegal ones.
        for (int i = 0; i < 8; i++) run_instr(ldi(i, int'($urandom_range(0, 127))));
        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 7));
            if (op == 5)
                run_instr(ldi(int'($urandom_range(0, 7)), int'($urandom_range(0, 127))));
            else
                run_instr(enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 7))));
        end
        check_all_regs("rand_regs");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/write-back controller that drives the combinational ALU port (op_a, op_b, op_select, result) from a small instruction stream. It owns an 8 x 16-bit register file, decodes one instruction at a time, presents operands to the ALU, captures the result and writes it back. It sits between the instruction source (fetch/testbench) and the ALU in the datapath.

## Interface
- NREGS, 8, register-file depth (fixed at 8; 3-bit register fields)
- WIDTH, 16, datapath width; must match ALU operand width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr  in  16  instruction word: [15:13] opcode, [12:10] rd, [9:7] ra, [6:4] rb; LDI uses [6:0] imm7
- instr_ready  out  1  controller can accept an instruction
- op_a  out  16  ALU operand A (registered)
- op_b  out  16  ALU operand B (registered)
- op_select  out  3  ALU operation (registered)
- result  in  16  ALU combinational result
- done  out  1  one-cycle pulse: write-back occurring this cycle
- wb_addr  out  3  register written when done=1
- wb_data  out  16  value written when done=1
- err  out  1  one-cycle pulse: illegal opcode rejected
- flag_z  out  1  last written value was zero
- flag_n  out  1  last written value bit 15
- dbg_addr  in  3  debug read address
- dbg_data  out  16  combinational read of register file at dbg_addr

## Operation
- Opcodes 0-4 (ADD, SUB, NAND, PASS_A, PASS_B): op_a=R[ra], op_b=R[rb], op_select=opcode, R[rd]<=result.
- Opcode 5 (LDI): op_a=0, op_b={9'b0, imm7}, op_select=3'b100 (PASS_B); R[rd]<=result. Routed through the ALU, not bypassed.
- Opcodes 6, 7: illegal; err pulses, no register write, no state change beyond IDLE.
- FSM states: IDLE, RD, EX, WB.
  - IDLE: instr_ready=1. On instr_valid=1: legal opcode -> latch rd, load op_a/op_b/op_select, go RD; illegal -> err=1 next cycle, stay IDLE.
  - RD: ALU settles on registered operands; go EX.
  - EX: result_q<=result; go WB.
  - WB: R[rd]<=result_q; done=1, wb_addr=rd, wb_data=result_q; go IDLE.
- instr_ready=0 in RD/EX/WB; instr_valid ignored there (no queuing).
- Arithmetic wraps modulo 2^16; no carry/overflow output.
- rd may equal ra/rb: operands are captured at accept, so old values are used.
- R0 is an ordinary writable register.

## Timing
- Accept at edge N (IDLE, instr_valid=1) -> operands on ALU ports from N+1 -> result captured edge N+2 -> done high cycle after N+2, register updated edge N+3 -> instr_ready high again after N+3.
- Throughput: one instruction per 4 cycles when instr_valid held high.
- dbg_data shows the pre-write value during the WB cycle, new value after edge N+3.
- err high exactly the cycle after the accepting edge of an illegal instruction.
- Reset (any state, including mid-instruction): state IDLE, all R[i]=0, op_a=0, op_b=0, op_select=0, result_q=0, done=0, err=0, wb_addr=0, wb_data=0, flag_z=0, flag_n=0; in-flight instruction discarded, no write-back. instr_ready=1 the cycle after reset deasserts.

## Configuration
- ALU_ISSUE_FLAGS_EN defined: flag_z/flag_n registers update at every write-back edge (flag_z = wb value==0, flag_n = wb value[15]); hold otherwise; cleared by reset.
- ALU_ISSUE_FLAGS_EN undefined: flag registers not built; flag_z and flag_n tied to 0. Ports exist in both builds.

## Test plan
- Reset then LDI R1,#5; LDI R2,#3 -> two done pulses, wb_data 5 then 3; dbg_addr=1 reads 0x0005.
- ADD R3,R1,R2 then SUB R4,R2,R1 -> wb_data 0x0008 then 0xFFFE; flag_n=1 after SUB (flags build), 0 otherwise.
- NAND R5,R1,R1 -> 0xFFFA; PASS_A R6,R3,R0 -> 0x0008; SUB R7,R1,R1 -> 0x0000, flag_z=1 (flags build).
- Opcode 6 with instr_valid=1 -> err pulse one cycle, no done, all registers unchanged, instr_ready stays 1.
- instr_valid held high with back-to-back ADDs -> accept every 4th cycle, instr_ready low 3 cycles each; ADD R1,R1,R1 from R1=5 yields 10 then 20.
- Reset asserted during EX of ADD R3,... -> no done, R3 reads 0, all outputs at reset values, next instruction executes normally.
